// File: rtl/heap_spill_agent.sv
// Memory-side responder for heap spill traffic: deep backing RAM plus an in-order FWFT response queue.
// Optional build macro HEAP_SPILL_STATS_EN adds saturating rd_count/wr_count outputs.
module heap_spill_agent #(
  parameter int W_D      = 32,
  parameter int W_BA     = 10,
  parameter int W_FIFO_A = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           wr_valid,
  input  logic [W_D-1:0] wr_addr,
  input  logic [W_D-1:0] wr_data,
  output logic           wr_ready,
  input  logic           rd_req_valid,
  input  logic [W_D-1:0] rd_req_addr,
  output logic           rd_req_ready,
  output logic [W_D-1:0] Q,
  input  logic           DEQ,
  output logic           EMPTY,
  output logic           ALM_EMPTY,
`ifdef HEAP_SPILL_STATS_EN
  output logic [31:0]    rd_count,
  output logic [31:0]    wr_count,
`endif
  output logic           range_error
);
  localparam int RAM_DEPTH = 1 << W_BA;
  localparam int DEPTH     = 1 << W_FIFO_A;
  localparam logic [W_FIFO_A:0]   DEPTH_L = (W_FIFO_A+1)'(DEPTH);
  localparam logic [W_FIFO_A:0]   CNT_ONE = (W_FIFO_A+1)'(1);
  localparam logic [W_FIFO_A-1:0] PTR_ONE = W_FIFO_A'(1);

  typedef enum logic [0:0] {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

  state_t              state_r, state_next_s;
  logic                wr_ready_r, ready_base_r, empty_r, alm_empty_r;
  logic                range_error_r, rd_oor_r;
  logic [W_D-1:0]      ram [RAM_DEPTH];
  logic [W_D-1:0]      ram_q_r;
  logic [W_D-1:0]      fifo_mem [DEPTH];
  logic [W_FIFO_A-1:0] head_r, tail_r;
  logic [W_FIFO_A:0]   count_r, count_next_s;
  logic                push_s, pop_s, wr_acc_s, rd_acc_s;
  logic                wr_in_range_s, rd_in_range_s;
  logic [W_D-1:0]      push_data_s;

  // Full-width compare: any set bit above the RAM address range is out of range.
  assign wr_in_range_s = (wr_addr[W_D-1:W_BA] == {(W_D-W_BA){1'b0}});
  assign rd_in_range_s = (rd_req_addr[W_D-1:W_BA] == {(W_D-W_BA){1'b0}});
  assign wr_acc_s      = wr_valid && wr_ready_r;
  assign rd_req_ready  = ready_base_r && !wr_valid;
  assign rd_acc_s      = rd_req_valid && rd_req_ready;
  assign pop_s         = DEQ && !empty_r;
  assign push_data_s   = rd_oor_r ? {W_D{1'b0}} : ram_q_r;

  assign wr_ready    = wr_ready_r;
  assign EMPTY       = empty_r;
  assign ALM_EMPTY   = alm_empty_r;
  assign range_error = range_error_r;
  assign Q           = fifo_mem[head_r];

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // FSM next state; the RD_WAIT cycle pushes the registered RAM output.
  always_comb begin
    state_next_s = state_r;
    push_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (rd_acc_s) state_next_s = RD_WAIT;
        else          state_next_s = IDLE;
      end
      RD_WAIT: begin
        push_s       = 1'b1;
        state_next_s = IDLE;
      end
      default: begin
        push_s       = 1'b0;
        state_next_s = IDLE;
      end
    endcase
  end

  // Queue occupancy after this cycle's push/pop.
  always_comb begin
    count_next_s = count_r;
    if (push_s && !pop_s)      count_next_s = count_r + CNT_ONE;
    else if (!push_s && pop_s) count_next_s = count_r - CNT_ONE;
    else                       count_next_s = count_r;
  end

  // Queue pointers, flags, ready registers and sticky range error.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_r        <= {W_FIFO_A{1'b0}};
      tail_r        <= {W_FIFO_A{1'b0}};
      count_r       <= {(W_FIFO_A+1){1'b0}};
      empty_r       <= 1'b1;
      alm_empty_r   <= 1'b1;
      wr_ready_r    <= 1'b1;
      ready_base_r  <= 1'b0;
      range_error_r <= 1'b0;
      rd_oor_r      <= 1'b0;
    end else begin
      if (push_s) tail_r <= tail_r + PTR_ONE;
      if (pop_s)  head_r <= head_r + PTR_ONE;
      count_r      <= count_next_s;
      empty_r      <= (count_next_s == {(W_FIFO_A+1){1'b0}});
      alm_empty_r  <= (count_next_s <= CNT_ONE);
      wr_ready_r   <= (state_next_s == IDLE);
      // Nothing is in flight whenever the next state is IDLE, so occupancy alone gates.
      ready_base_r <= (state_next_s == IDLE) && (count_next_s < DEPTH_L);
      if (rd_acc_s) rd_oor_r <= !rd_in_range_s;
      if ((wr_acc_s && !wr_in_range_s) || (rd_acc_s && !rd_in_range_s))
        range_error_r <= 1'b1;
    end
  end

  // Backing RAM: contents survive reset; read data is registered at accept.
  always_ff @(posedge CLK) begin
    if (wr_acc_s && wr_in_range_s) ram[wr_addr[W_BA-1:0]] <= wr_data;
    if (rd_acc_s) ram_q_r <= ram[rd_req_addr[W_BA-1:0]];
  end

  // Response queue storage.
  always_ff @(posedge CLK) begin
    if (push_s) fifo_mem[tail_r] <= push_data_s;
  end

`ifdef HEAP_SPILL_STATS_EN
  logic [31:0] rd_count_r, wr_count_r;

  // Saturating counters of accepted requests.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_count_r <= 32'd0;
      wr_count_r <= 32'd0;
    end else begin
      if (rd_acc_s && (rd_count_r != 32'hffff_ffff)) rd_count_r <= rd_count_r + 32'd1;
      if (wr_acc_s && (wr_count_r != 32'hffff_ffff)) wr_count_r <= wr_count_r + 32'd1;
    end
  end

  assign rd_count = rd_count_r;
  assign wr_count = wr_count_r;
`endif
endmodule

// File: tb/tb_heap_spill_agent.sv
// Directed self-checking bench for heap_spill_agent (W_FIFO_A=2, so the queue holds 4 entries).
module tb_heap_spill_agent;
  logic        CLK, RST;
  logic        wr_valid, rd_req_valid, DEQ;
  logic [31:0] wr_addr, wr_data, rd_req_addr;
  logic        wr_ready, rd_req_ready, EMPTY, ALM_EMPTY, range_error;
  logic [31:0] Q;
`ifdef HEAP_SPILL_STATS_EN
  logic [31:0] rd_count, wr_count;
`endif
  int total = 0;
  int bad   = 0;

  heap_spill_agent #(.W_D(32), .W_BA(10), .W_FIFO_A(2)) dut (
    .CLK(CLK), .RST(RST),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
    .Q(Q), .DEQ(DEQ), .EMPTY(EMPTY), .ALM_EMPTY(ALM_EMPTY),
`ifdef HEAP_SPILL_STATS_EN
    .rd_count(rd_count), .wr_count(wr_count),
`endif
    .range_error(range_error)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    @(negedge CLK);
    wr_valid = 1'b0;
  endtask

  // Returns just after the accepting edge (state is then RD_WAIT).
  task automatic do_read(input logic [31:0] a, output bit ok);
    ok = 1'b0;
    @(negedge CLK);
    rd_req_valid = 1'b1; rd_req_addr = a;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (rd_req_ready) begin
        @(posedge CLK);
        ok = 1'b1;
      end else begin
        @(negedge CLK);
      end
    end
    #1;
    rd_req_valid = 1'b0;
  endtask

  task automatic pop;
    @(negedge CLK);
    DEQ = 1'b1;
    @(negedge CLK);
    DEQ = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    total++; if (EMPTY !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", EMPTY); end
    total++; if (ALM_EMPTY !== 1'b1) begin bad++; $display("FAIL rst_alm_empty got=%b exp=1", ALM_EMPTY); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL rst_wr_ready got=%b exp=1", wr_ready); end
    total++; if (range_error !== 1'b0) begin bad++; $display("FAIL rst_range_error got=%b exp=0", range_error); end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    total++; if (rd_req_ready !== 1'b0) begin bad++; $display("FAIL rst_rd_ready_before_edge got=%b exp=0", rd_req_ready); end
    @(posedge CLK); #1;
    total++; if (rd_req_ready !== 1'b1) begin bad++; $display("FAIL rd_ready_after_edge got=%b exp=1", rd_req_ready); end
  endtask

  task automatic test_basic;
    bit ok;
    do_write(32'd5, 32'd77);
    do_read(32'd5, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL basic_accept got=%b exp=1", ok); end
    total++; if (EMPTY !== 1'b1) begin bad++; $display("FAIL basic_empty_at_n got=%b exp=1", EMPTY); end
    @(posedge CLK); #1;
    total++; if (EMPTY !== 1'b0) begin bad++; $display("FAIL basic_empty_at_n1 got=%b exp=0", EMPTY); end
    total++; if (Q !== 32'd77) begin bad++; $display("FAIL basic_q got=%0d exp=77", Q); end
    pop();
    total++; if (EMPTY !== 1'b1) begin bad++; $display("FAIL basic_empty_after_deq got=%b exp=1", EMPTY); end
    pop();
    total++; if (EMPTY !== 1'b1) begin bad++; $display("FAIL deq_when_empty got=%b exp=1", EMPTY); end
  endtask

  task automatic test_write_priority;
    @(negedge CLK);
    wr_valid = 1'b1; wr_addr = 32'd9; wr_data = 32'd3;
    rd_req_valid = 1'b1; rd_req_addr = 32'd9;
    #1;
    total++; if (rd_req_ready !== 1'b0) begin bad++; $display("FAIL prio_rd_ready got=%b exp=0", rd_req_ready); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL prio_wr_ready got=%b exp=1", wr_ready); end
    @(negedge CLK);
    wr_valid = 1'b0;
    #1;
    total++; if (rd_req_ready !== 1'b1) begin bad++; $display("FAIL prio_rd_ready_next got=%b exp=1", rd_req_ready); end
    @(posedge CLK); #1;
    rd_req_valid = 1'b0;
    @(posedge CLK); #1;
    total++; if (Q !== 32'd3) begin bad++; $display("FAIL prio_q got=%0d exp=3", Q); end
    pop();
  endtask

  task automatic test_queue_full;
    bit ok;
    for (int i = 0; i < 5; i++) do_write(32'd10 + 32'(i), 32'd100 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      do_read(32'd10 + 32'(i), ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL full_accept%0d got=%b exp=1", i, ok); end
      @(posedge CLK); #1;
    end
    total++; if (ALM_EMPTY !== 1'b0) begin bad++; $display("FAIL full_alm_empty got=%b exp=0", ALM_EMPTY); end
    @(negedge CLK);
    rd_req_valid = 1'b1; rd_req_addr = 32'd14;
    #1;
    total++; if (rd_req_ready !== 1'b0) begin bad++; $display("FAIL full_rd_ready got=%b exp=0", rd_req_ready); end
    @(negedge CLK); #1;
    total++; if (rd_req_ready !== 1'b0) begin bad++; $display("FAIL full_rd_ready_hold got=%b exp=0", rd_req_ready); end
    rd_req_valid = 1'b0;
    total++; if (Q !== 32'd100) begin bad++; $display("FAIL full_head got=%0d exp=100", Q); end
    pop();
    do_read(32'd14, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL full_accept_after_deq got=%b exp=1", ok); end
    @(posedge CLK); #1;
    for (int i = 1; i < 5; i++) begin
      total++; if (Q !== 32'd100 + 32'(i)) begin bad++; $display("FAIL full_order%0d got=%0d exp=%0d", i, Q, 100 + i); end
      pop();
    end
    total++; if (EMPTY !== 1'b1) begin bad++; $display("FAIL full_drained got=%b exp=1", EMPTY); end
  endtask

  task automatic test_range;
    bit ok;
    do_write(32'd0, 32'd11);
    total++; if (range_error !== 1'b0) begin bad++; $display("FAIL range_before got=%b exp=0", range_error); end
    do_write(32'd1024, 32'd55);
    total++; if (range_error !== 1'b1) begin bad++; $display("FAIL range_set got=%b exp=1", range_error); end
    do_read(32'd0, ok);
    @(posedge CLK); #1;
    total++; if (Q !== 32'd11) begin bad++; $display("FAIL range_no_alias got=%0d exp=11", Q); end
    pop();
    do_read(32'd1024, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL range_rd_accept got=%b exp=1", ok); end
    @(posedge CLK); #1;
    total++; if (Q !== 32'd0 || EMPTY !== 1'b0) begin bad++; $display("FAIL range_rd_zero got=%0d/%b exp=0/0", Q, EMPTY); end
    pop();
    repeat (3) @(posedge CLK);
    #1;
    total++; if (range_error !== 1'b1) begin bad++; $display("FAIL range_sticky got=%b exp=1", range_error); end
  endtask

  task automatic test_reset_mid_read;
    bit ok;
    do_write(32'd3, 32'd33);
    do_read(32'd3, ok);
    @(posedge CLK); #1;
    do_read(32'd3, ok);
    RST = 1'b1;
    #1;
    total++; if (EMPTY !== 1'b1) begin bad++; $display("FAIL midrst_empty got=%b exp=1", EMPTY); end
    total++; if (range_error !== 1'b0) begin bad++; $display("FAIL midrst_range got=%b exp=0", range_error); end
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    total++; if (EMPTY !== 1'b1) begin bad++; $display("FAIL midrst_no_push got=%b exp=1", EMPTY); end
    do_read(32'd3, ok);
    @(posedge CLK); #1;
    total++; if (Q !== 32'd33) begin bad++; $display("FAIL midrst_ram_kept got=%0d exp=33", Q); end
    pop();
  endtask

`ifdef HEAP_SPILL_STATS_EN
  task automatic test_stats;
    bit ok;
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    #1;
    total++; if (wr_count !== 32'd0 || rd_count !== 32'd0) begin bad++; $display("FAIL stats_zero got=%0d/%0d exp=0/0", wr_count, rd_count); end
    for (int i = 0; i < 3; i++) do_write(32'd20 + 32'(i), 32'(i));
    for (int i = 0; i < 2; i++) begin
      do_read(32'd20, ok);
      @(posedge CLK); #1;
    end
    pop(); pop();
    total++; if (wr_count !== 32'd3) begin bad++; $display("FAIL stats_wr got=%0d exp=3", wr_count); end
    total++; if (rd_count !== 32'd2) begin bad++; $display("FAIL stats_rd got=%0d exp=2", rd_count); end
    @(negedge CLK); RST = 1'b1;
    #1;
    total++; if (wr_count !== 32'd0 || rd_count !== 32'd0) begin bad++; $display("FAIL stats_clear got=%0d/%0d exp=0/0", wr_count, rd_count); end
    @(negedge CLK); RST = 1'b0;
  endtask
`endif

  initial begin
    RST = 1'b1;
    wr_valid = 1'b0; wr_addr = 32'd0; wr_data = 32'd0;
    rd_req_valid = 1'b0; rd_req_addr = 32'd0; DEQ = 1'b0;
    test_reset();
    test_basic();
    test_write_priority();
    test_queue_full();
    test_range();
    test_reset_mid_read();
`ifdef HEAP_SPILL_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
